operand_entry: RTL and testbench
================================

OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 Parameter DEB_CYCLES, default 500000, consecutive stable clocks before a key level change is accepted (10 ms at 50 MHz).
REQ-002 CLOCK_50  input  1  system clock; all logic rising-edge on this single clock.
REQ-003 RST_N  input  1  reset; synchronous, active-low.
REQ-004 SW  input  4  operand value from switches, BCD digit expected.
REQ-005 KEY_ENTER  input  1  raw pushbutton, active-low (pressed = 0), asynchronous to CLOCK_50.
REQ-006 KEY_CLEAR  input  1  raw pushbutton, active-low, asynchronous to CLOCK_50.
REQ-007 ACK  input  1  downstream adder/display stage has consumed the operand pair.
REQ-008 OP_A, OP_B  output  4 each  captured operands, fed to the 4-bit adder/7-segment stage.
REQ-009 VALID  output  1  operand pair complete and held stable.
REQ-010 ERR  output  1  one-cycle pulse, rejected entry.
REQ-011 STATE  output  2  current FSM state, drives LED indicators.

Function
REQ-012 Each key SHALL pass a 2-flop synchronizer, then conditioning, then falling-edge detection producing a one-cycle press pulse.
REQ-013 Conditioned level SHALL change only after the synchronized level differs from it for DEB_CYCLES consecutive clocks; any bounce restarts the count.
REQ-014 FSM states SHALL be WAIT_A=0, WAIT_B=1, READY=2; encoding 3 unused and SHALL return to WAIT_A next cycle.
REQ-015 WAIT_A + enter pulse + SW<=9: OP_A<=SW, go WAIT_B; SW>9: ERR pulse, OP_A unchanged, stay.
REQ-016 WAIT_B + enter pulse + SW<=9: OP_B<=SW, VALID<=1, go READY; SW>9: ERR pulse, stay.
REQ-017 Captured values and VALID SHALL be visible the cycle after the enter pulse (1-cycle latency).
REQ-018 READY: VALID, OP_A, OP_B SHALL hold; enter pulses ignored; ACK=1 clears VALID and goes WAIT_A next cycle, OP_A/OP_B retained.
REQ-019 ACK outside READY SHALL be ignored.
REQ-020 Clear pulse in any state: go WAIT_A, OP_A=OP_B=0, VALID=0 next cycle.
REQ-021 Clear and enter pulses in the same cycle: clear wins, no capture, no ERR.
REQ-022 ACK and clear in same READY cycle: clear behaviour.
REQ-023 Holding a key SHALL produce exactly one press pulse; release produces none.

Reset
REQ-024 RST_N=0 at a clock edge: STATE=WAIT_A, OP_A=OP_B=0, VALID=0, ERR=0, synchronizers and conditioned levels = 1 (released), counters = 0.
REQ-025 Reset mid-debounce or in READY SHALL discard all progress; no press pulse generated from pre-reset activity.

Configuration
REQ-026 Macro OPERAND_ENTRY_DEBOUNCE_EN defined: REQ-013 counter conditioning active.
REQ-027 Macro undefined: no counter; conditioned level = synchronized level; DEB_CYCLES ignored; press pulse 3 clocks after raw falling edge.

Structure
REQ-028 Package operand_entry_pkg SHALL hold state typedef/encodings (WAIT_A, WAIT_B, READY) and constant BCD_MAX=9.
REQ-029 Sub-module key_conditioner (sync, optional debounce, falling-edge pulse) SHALL be instantiated once per key.

Verification (DEB_CYCLES=4, macro defined unless stated)
REQ-030 SW=3, clean ENTER press; SW=5, press -> OP_A=3, OP_B=5, VALID=1, STATE=2; ACK one cycle -> VALID=0, STATE=0.
REQ-031 ENTER toggling every 2 clocks for 20 clocks then held low -> exactly one capture, after 4 stable clocks.
REQ-032 WAIT_A, SW=12, press -> ERR one cycle, STATE=0, OP_A=0.
REQ-033 READY, CLEAR and ENTER pressed same cycle -> STATE=0, OP_A=OP_B=0, VALID=0, ERR=0.
REQ-034 WAIT_B, RST_N low one clock while ENTER counting -> all outputs reset values, no capture after release.
REQ-035 Macro undefined, single ENTER falling edge -> press pulse exactly 3 clocks later, capture next cycle.

Source files
------------

// File: rtl/operand_entry_pkg.sv
// ----------------------------------------------------------------------------
// operand_entry_pkg
// Shared definitions for the operand entry block: the FSM state encoding,
// the largest legal BCD digit and a small helper that checks whether a
// switch value is a valid BCD digit.
//
// Build option: OPERAND_ENTRY_DEBOUNCE_EN (see key_conditioner) does not
// change anything in this package.
// ----------------------------------------------------------------------------
package operand_entry_pkg;

    // Entry sequence. Encoding 2'd3 is unused; the FSM sends it back to
    // WAIT_A on the next clock.
    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        READY  = 2'd2
    } state_e;

    // Largest digit accepted from the switches.
    localparam logic [3:0] BCD_MAX = 4'd9;

    // True when the switch value is a decimal digit 0..9.
    function automatic logic isBcd(input logic [3:0] value);
        return (value <= BCD_MAX);
    endfunction

endpackage

// File: rtl/operand_entry_if.sv
// ----------------------------------------------------------------------------
// operand_entry_if
// Groups the switch/key inputs, the downstream ACK and the captured operand
// outputs of operand_entry into one bundle.
//
//   SW        [3:0]  operand digit from the switches
//   KEY_ENTER        raw pushbutton, pressed = 0, asynchronous
//   KEY_CLEAR        raw pushbutton, pressed = 0, asynchronous
//   ACK              downstream stage consumed the operand pair
//   OP_A/OP_B [3:0]  captured operands
//   VALID            operand pair complete and held
//   ERR              one-cycle pulse on a rejected digit
//   STATE     [1:0]  current entry state (LED indicators)
//
// Modports: master = the side producing switches/keys/ACK (board or bench),
//           slave  = operand_entry itself.
// ----------------------------------------------------------------------------
interface operand_entry_if;
    import operand_entry_pkg::*;

    logic [3:0] SW;
    logic       KEY_ENTER;
    logic       KEY_CLEAR;
    logic       ACK;
    logic [3:0] OP_A;
    logic [3:0] OP_B;
    logic       VALID;
    logic       ERR;
    state_e     STATE;

    modport master (
        output SW, KEY_ENTER, KEY_CLEAR, ACK,
        input  OP_A, OP_B, VALID, ERR, STATE
    );

    modport slave (
        input  SW, KEY_ENTER, KEY_CLEAR, ACK,
        output OP_A, OP_B, VALID, ERR, STATE
    );

endinterface

// File: rtl/operand_entry_key_conditioner.sv
// ----------------------------------------------------------------------------
// key_conditioner
// Turns one raw, active-low, asynchronous pushbutton into a single-cycle
// press pulse: 2-flop synchronizer -> optional debounce -> falling-edge
// detector (registered).
//
//   clk_i    system clock (rising edge)
//   rst_ni   synchronous, active-low reset
//   key_i    raw pushbutton level, pressed = 0
//   press_o  one-cycle pulse per accepted press
//
// Build option OPERAND_ENTRY_DEBOUNCE_EN:
//   defined   - the conditioned level follows the synchronized level only
//               after DEB_CYCLES consecutive clocks of disagreement; the
//               press pulse appears DEB_CYCLES+3 clocks after a clean edge.
//   undefined - no counter, the conditioned level is the synchronized level
//               and DEB_CYCLES has no effect; the pulse appears 3 clocks
//               after the raw falling edge.
// ----------------------------------------------------------------------------
module key_conditioner #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic press_o
);

    logic sync1_q;
    logic sync2_q;
    logic level;
    logic last_q;
    logic press_q;

    // Two-flop synchronizer. Both stages reset to the released level so a
    // reset never manufactures an edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             cond_q;
    logic             cond_d;

    // Debounce: count clocks during which the synchronized level disagrees
    // with the accepted level. Any clock of agreement (a bounce back)
    // restarts the count; on the DEB_CYCLES-th disagreeing clock the new
    // level is accepted.
    always_comb begin
        cnt_d  = '0;
        cond_d = cond_q;
        if (sync2_q != cond_q) begin
            if (cnt_q == CNT_LAST) begin
                cond_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state registers; reset forgets any half-finished count.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            cond_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            cond_q <= cond_d;
        end
    end

    assign level = cond_q;
`else
    // The debounce length has no effect in this build.
    localparam int deb_cycles_unused = DEB_CYCLES;

    assign level = sync2_q;
`endif

    // Falling-edge detector on the conditioned level. The pulse itself is
    // registered, which gives a fixed latency and a glitch-free output.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q  <= 1'b1;
            press_q <= 1'b0;
        end else begin
            last_q  <= level;
            press_q <= last_q & ~level;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/operand_entry.sv
// ----------------------------------------------------------------------------
// operand_entry
// Collects two BCD operands from the switches using an ENTER pushbutton and
// hands the pair to a downstream adder/display stage with a VALID/ACK
// handshake. A CLEAR pushbutton restarts entry at any time.
//
//   CLOCK_50  system clock, all logic on its rising edge
//   RST_N     synchronous, active-low reset
//   bus_if    operand_entry_if.slave: SW, KEY_ENTER, KEY_CLEAR, ACK in;
//             OP_A, OP_B, VALID, ERR, STATE out
//
// Parameter DEB_CYCLES: stable clocks before a key level change is accepted.
// Build option OPERAND_ENTRY_DEBOUNCE_EN enables the debounce counter inside
// key_conditioner; without it the keys are only synchronized.
// ----------------------------------------------------------------------------
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int DEB_CYCLES = 500000
) (
    input  logic              CLOCK_50,
    input  logic              RST_N,
    operand_entry_if.slave    bus_if
);

    logic       enterPress;
    logic       clearPress;
    state_e     state_q;
    state_e     state_d;
    logic [3:0] opA_q;
    logic [3:0] opB_q;
    logic       valid_q;
    logic       err_q;
    logic       loadA;
    logic       loadB;
    logic       err_d;

    // One conditioner per key; each turns a raw button into a press pulse.
    key_conditioner #(
        .DEB_CYCLES (DEB_CYCLES)
    ) uEnterKey (
        .clk_i   (CLOCK_50),
        .rst_ni  (RST_N),
        .key_i   (bus_if.KEY_ENTER),
        .press_o (enterPress)
    );

    key_conditioner #(
        .DEB_CYCLES (DEB_CYCLES)
    ) uClearKey (
        .clk_i   (CLOCK_50),
        .rst_ni  (RST_N),
        .key_i   (bus_if.KEY_CLEAR),
        .press_o (clearPress)
    );

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            state_q <= WAIT_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Clear overrides everything, including a same-cycle
    // enter or ACK. The unused encoding falls back to WAIT_A.
    always_comb begin
        state_d = state_q;
        if (clearPress) begin
            state_d = WAIT_A;
        end else begin
            case (state_q)
                WAIT_A:  if (loadA) state_d = WAIT_B;
                WAIT_B:  if (loadB) state_d = READY;
                READY:   if (bus_if.ACK) state_d = WAIT_A;
                default: state_d = WAIT_A;
            endcase
        end
    end

    // Output/control decode: which operand to load and whether to flag a
    // rejected digit. Enter pulses in READY are ignored and a clear pulse
    // suppresses both capture and error.
    always_comb begin
        loadA = 1'b0;
        loadB = 1'b0;
        err_d = 1'b0;
        if (!clearPress && enterPress) begin
            case (state_q)
                WAIT_A: begin
                    if (isBcd(bus_if.SW)) loadA = 1'b1;
                    else                  err_d = 1'b1;
                end
                WAIT_B: begin
                    if (isBcd(bus_if.SW)) loadB = 1'b1;
                    else                  err_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Operand and flag registers. VALID is simply "next state is READY",
    // so it rises with the second capture and drops with ACK or clear.
    // ACK keeps the operands; clear zeroes them.
    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            opA_q   <= 4'd0;
            opB_q   <= 4'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (clearPress) begin
                opA_q <= 4'd0;
                opB_q <= 4'd0;
            end else begin
                if (loadA) opA_q <= bus_if.SW;
                if (loadB) opB_q <= bus_if.SW;
            end
            valid_q <= (state_d == READY);
            err_q   <= err_d;
        end
    end

    assign bus_if.OP_A  = opA_q;
    assign bus_if.OP_B  = opB_q;
    assign bus_if.VALID = valid_q;
    assign bus_if.ERR   = err_q;
    assign bus_if.STATE = state_q;

endmodule

// File: tb/tb_operand_entry.sv
// ----------------------------------------------------------------------------
// tb_operand_entry
// Directed bench for operand_entry with DEB_CYCLES = 4. Works in both builds
// of OPERAND_ENTRY_DEBOUNCE_EN; the key-to-capture latency is derived from
// the build option.
// ----------------------------------------------------------------------------
module tb_operand_entry;
    import operand_entry_pkg::*;

    localparam int DEB = 4;
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    // Raw edge -> sync (2) -> DEB disagreeing clocks -> registered pulse.
    localparam int LAT = DEB + 3;
    localparam int MID = 4;
`else
    localparam int LAT = 3;
    localparam int MID = 2;
`endif

    logic CLOCK_50 = 1'b0;
    logic RST_N    = 1'b0;
    int   vecCount  = 0;
    int   missCount = 0;

    operand_entry_if bus ();

    operand_entry #(
        .DEB_CYCLES (DEB)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RST_N    (RST_N),
        .bus_if   (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    // Drive the input levels (keys are active-low).
    task automatic applyStimulus(input logic enterN, input logic clearN,
                                 input logic ack, input logic [3:0] sw);
        bus.KEY_ENTER = enterN;
        bus.KEY_CLEAR = clearN;
        bus.ACK       = ack;
        bus.SW        = sw;
    endtask

    // Full clean ENTER press with digit sw, then release and let it settle.
    task automatic enterDigit(input logic [3:0] sw);
        applyStimulus(1'b0, 1'b1, 1'b0, sw);
        tick(LAT + 1);
        applyStimulus(1'b1, 1'b1, 1'b0, sw);
        tick(LAT + 2);
    endtask

    task automatic pressClear();
        applyStimulus(1'b1, 1'b0, 1'b0, bus.SW);
        tick(LAT + 1);
        applyStimulus(1'b1, 1'b1, 1'b0, bus.SW);
        tick(LAT + 2);
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        RST_N = 1'b0;
        tick(2);
        vecCount++; if (bus.STATE !== WAIT_A) begin missCount++; $display("[TB] FAIL reset_state: got %0d want 0", bus.STATE); end
        vecCount++; if (bus.OP_A !== 4'd0) begin missCount++; $display("[TB] FAIL reset_opA: got %0d want 0", bus.OP_A); end
        vecCount++; if (bus.OP_B !== 4'd0) begin missCount++; $display("[TB] FAIL reset_opB: got %0d want 0", bus.OP_B); end
        vecCount++; if (bus.VALID !== 1'b0) begin missCount++; $display("[TB] FAIL reset_valid: got %0b want 0", bus.VALID); end
        vecCount++; if (bus.ERR !== 1'b0) begin missCount++; $display("[TB] FAIL reset_err: got %0b want 0", bus.ERR); end
        RST_N = 1'b1;
        tick(1);
    endtask

    task automatic test_basic_entry();
        // Operand A = 3; capture lands exactly one clock after the pulse.
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd3);
        tick(LAT);
        vecCount++; if (bus.STATE !== WAIT_A) begin missCount++; $display("[TB] FAIL latency_early: got %0d want 0", bus.STATE); end
        tick(1);
        vecCount++; if (bus.STATE !== WAIT_B) begin missCount++; $display("[TB] FAIL basic_stateB: got %0d want 1", bus.STATE); end
        vecCount++; if (bus.OP_A !== 4'd3) begin missCount++; $display("[TB] FAIL basic_opA: got %0d want 3", bus.OP_A); end
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd3);
        tick(LAT + 2);
        // Operand B = 5.
        enterDigit(4'd5);
        vecCount++; if (bus.STATE !== READY) begin missCount++; $display("[TB] FAIL basic_ready: got %0d want 2", bus.STATE); end
        vecCount++; if (bus.OP_B !== 4'd5) begin missCount++; $display("[TB] FAIL basic_opB: got %0d want 5", bus.OP_B); end
        vecCount++; if (bus.VALID !== 1'b1) begin missCount++; $display("[TB] FAIL basic_valid: got %0b want 1", bus.VALID); end
        // Enter in READY is ignored.
        enterDigit(4'd7);
        vecCount++; if (bus.OP_B !== 4'd5) begin missCount++; $display("[TB] FAIL ready_hold_opB: got %0d want 5", bus.OP_B); end
        vecCount++; if (bus.STATE !== READY) begin missCount++; $display("[TB] FAIL ready_hold_state: got %0d want 2", bus.STATE); end
        // ACK one cycle: back to WAIT_A, operands retained.
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd7);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd7);
        vecCount++; if (bus.STATE !== WAIT_A) begin missCount++; $display("[TB] FAIL ack_state: got %0d want 0", bus.STATE); end
        vecCount++; if (bus.VALID !== 1'b0) begin missCount++; $display("[TB] FAIL ack_valid: got %0b want 0", bus.VALID); end
        vecCount++; if (bus.OP_A !== 4'd3) begin missCount++; $display("[TB] FAIL ack_keep_opA: got %0d want 3", bus.OP_A); end
    endtask

    task automatic test_ack_ignored();
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd0);
        tick(2);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        vecCount++; if (bus.STATE !== WAIT_A) begin missCount++; $display("[TB] FAIL ack_idle_state: got %0d want 0", bus.STATE); end
        vecCount++; if (bus.VALID !== 1'b0) begin missCount++; $display("[TB] FAIL ack_idle_valid: got %0b want 0", bus.VALID); end
    endtask

    task automatic test_error();
        pressClear();
        vecCount++; if (bus.OP_A !== 4'd0) begin missCount++; $display("[TB] FAIL clear_opA: got %0d want 0", bus.OP_A); end
        vecCount++; if (bus.OP_B !== 4'd0) begin missCount++; $display("[TB] FAIL clear_opB: got %0d want 0", bus.OP_B); end
        // SW = 12 in WAIT_A.
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd12);
        tick(LAT + 1);
        vecCount++; if (bus.ERR !== 1'b1) begin missCount++; $display("[TB] FAIL errA_pulse: got %0b want 1", bus.ERR); end
        vecCount++; if (bus.STATE !== WAIT_A) begin missCount++; $display("[TB] FAIL errA_state: got %0d want 0", bus.STATE); end
        vecCount++; if (bus.OP_A !== 4'd0) begin missCount++; $display("[TB] FAIL errA_opA: got %0d want 0", bus.OP_A); end
        tick(1);
        vecCount++; if (bus.ERR !== 1'b0) begin missCount++; $display("[TB] FAIL errA_width: got %0b want 0", bus.ERR); end
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd12);
        tick(LAT + 2);
        // SW = 10 in WAIT_B.
        enterDigit(4'd2);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd10);
        tick(LAT + 1);
        vecCount++; if (bus.ERR !== 1'b1) begin missCount++; $display("[TB] FAIL errB_pulse: got %0b want 1", bus.ERR); end
        vecCount++; if (bus.STATE !== WAIT_B) begin missCount++; $display("[TB] FAIL errB_state: got %0d want 1", bus.STATE); end
        vecCount++; if (bus.OP_B !== 4'd0) begin missCount++; $display("[TB] FAIL errB_opB: got %0d want 0", bus.OP_B); end
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd10);
        tick(LAT + 2);
    endtask

    task automatic test_reset_mid();
        // Still in WAIT_B with OP_A = 2; start a press, reset mid-way.
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd6);
        tick(MID);
        RST_N = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd6);
        tick(1);
        vecCount++; if (bus.STATE !== WAIT_A) begin missCount++; $display("[TB] FAIL rstmid_state: got %0d want 0", bus.STATE); end
        vecCount++; if (bus.OP_A !== 4'd0) begin missCount++; $display("[TB] FAIL rstmid_opA: got %0d want 0", bus.OP_A); end
        RST_N = 1'b1;
        tick(LAT + 4);
        vecCount++; if (bus.STATE !== WAIT_A) begin missCount++; $display("[TB] FAIL rstmid_nocap: got %0d want 0", bus.STATE); end
        vecCount++; if (bus.OP_A !== 4'd0) begin missCount++; $display("[TB] FAIL rstmid_opA_after: got %0d want 0", bus.OP_A); end
    endtask

    task automatic test_hold_release();
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd4);
        tick(LAT + 1);
        vecCount++; if (bus.OP_A !== 4'd4) begin missCount++; $display("[TB] FAIL hold_opA: got %0d want 4", bus.OP_A); end
        tick(20);
        vecCount++; if (bus.STATE !== WAIT_B) begin missCount++; $display("[TB] FAIL hold_single: got %0d want 1", bus.STATE); end
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd4);
        tick(LAT + 4);
        vecCount++; if (bus.STATE !== WAIT_B) begin missCount++; $display("[TB] FAIL release_nopulse: got %0d want 1", bus.STATE); end
        pressClear();
    endtask

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    task automatic test_bounce();
        // Toggle every 2 clocks for 20 clocks, then hold low.
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i % 2) != 0, 1'b1, 1'b0, 4'd8);
            tick(2);
        end
        vecCount++; if (bus.STATE !== WAIT_A) begin missCount++; $display("[TB] FAIL bounce_nocap: got %0d want 0", bus.STATE); end
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd8);
        tick(LAT);
        vecCount++; if (bus.STATE !== WAIT_A) begin missCount++; $display("[TB] FAIL bounce_early: got %0d want 0", bus.STATE); end
        tick(1);
        vecCount++; if (bus.OP_A !== 4'd8) begin missCount++; $display("[TB] FAIL bounce_opA: got %0d want 8", bus.OP_A); end
        tick(10);
        vecCount++; if (bus.STATE !== WAIT_B) begin missCount++; $display("[TB] FAIL bounce_once: got %0d want 1", bus.STATE); end
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd8);
        tick(LAT + 2);
        pressClear();
    endtask
`endif

    task automatic test_clear_enter_ready();
        enterDigit(4'd1);
        enterDigit(4'd2);
        vecCount++; if (bus.STATE !== READY) begin missCount++; $display("[TB] FAIL ce_setup: got %0d want 2", bus.STATE); end
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd9);
        tick(LAT + 1);
        vecCount++; if (bus.STATE !== WAIT_A) begin missCount++; $display("[TB] FAIL ce_state: got %0d want 0", bus.STATE); end
        vecCount++; if (bus.OP_A !== 4'd0) begin missCount++; $display("[TB] FAIL ce_opA: got %0d want 0", bus.OP_A); end
        vecCount++; if (bus.OP_B !== 4'd0) begin missCount++; $display("[TB] FAIL ce_opB: got %0d want 0", bus.OP_B); end
        vecCount++; if (bus.VALID !== 1'b0) begin missCount++; $display("[TB] FAIL ce_valid: got %0b want 0", bus.VALID); end
        vecCount++; if (bus.ERR !== 1'b0) begin missCount++; $display("[TB] FAIL ce_err: got %0b want 0", bus.ERR); end
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd9);
        tick(LAT + 2);
    endtask

    task automatic test_ack_clear();
        enterDigit(4'd3);
        enterDigit(4'd4);
        // Line ACK up with the cycle the clear pulse is high.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd4);
        tick(LAT);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd4);
        tick(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd4);
        vecCount++; if (bus.STATE !== WAIT_A) begin missCount++; $display("[TB] FAIL ackclr_state: got %0d want 0", bus.STATE); end
        vecCount++; if (bus.OP_A !== 4'd0) begin missCount++; $display("[TB] FAIL ackclr_opA: got %0d want 0", bus.OP_A); end
        vecCount++; if (bus.OP_B !== 4'd0) begin missCount++; $display("[TB] FAIL ackclr_opB: got %0d want 0", bus.OP_B); end
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd4);
        tick(LAT + 2);
    endtask

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        test_reset();
        test_basic_entry();
        test_ack_ignored();
        test_error();
        test_reset_mid();
        test_hold_release();
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
        test_bounce();
`endif
        test_clear_enter_ready();
        test_ack_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
